// File: rtl/proc16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc16_pkg
// Purpose  : Shared constants for the 16-bit processor datapath blocks.
//            Holds the destination select codes used by the result-bus
//            demultiplexer, the default data width and the channel count.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package proc16_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int NUM_CH        = 3;

  localparam logic [1:0] SEL_CH0 = 2'd0;
  localparam logic [1:0] SEL_CH1 = 2'd1;
  localparam logic [1:0] SEL_CH2 = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

  // True for select codes that address a real output channel.
  function automatic logic sel_is_channel(input logic [1:0] sel);
    return (sel != SEL_BAD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_out_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_out_slot
// Purpose  : One output channel of the buffered demultiplexer: a single-entry
//            holding register with a valid flag and valid/ready handshake.
// Ports    : clk        - system clock
//            reset      - asynchronous active-high reset
//            load       - write load_data into the slot at the next edge
//            load_data  - word to capture
//            ready      - consumer takes the held word this cycle
//            data       - held word (registered)
//            valid      - slot holds a word (registered)
//            free       - slot can accept a word this cycle (combinational)
// Revision : 1.0  initial release
// ============================================================================
module demux_out_slot
  import proc16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // A slot draining this cycle can be refilled in the same cycle, which
  // gives one word per cycle per channel.
  assign free = !r_valid || ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (load) begin
        r_data  <= load_data;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        // Drain only; data is left as-is.
        r_valid <= 1'b0;
      end
    end
  end

  assign data  = r_data;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/demux16b3_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux16b3_buf
// Purpose  : Buffered 1-to-3 demultiplexer for datapath words. Steers a word
//            to one of three channels by a 2-bit select; each channel holds
//            one word behind a valid/ready handshake. Select code 3 is
//            illegal: the word is dropped, err pulses and a saturating
//            counter records it.
// Ports    : clk, reset               - clock, async active-high reset
//            in_data, set, in_valid   - input word, destination, valid
//            in_ready                 - input accepted this cycle (comb)
//            outK_data/valid/ready    - channel K handshake, K = 0..2
//            err                      - pulse after an illegal accept
//            err_count                - saturating illegal-accept count
// Revision : 1.0  initial release
// ============================================================================
module demux16b3_buf
  import proc16_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           set,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out0_data,
  output logic [WIDTH-1:0]     out1_data,
  output logic [WIDTH-1:0]     out2_data,
  output logic                 out0_valid,
  output logic                 out1_valid,
  output logic                 out2_valid,
  input  logic                 out0_ready,
  input  logic                 out1_ready,
  input  logic                 out2_ready,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] c_ERR_MAX = '1;

  logic [NUM_CH-1:0] w_ready;
  logic [NUM_CH-1:0] w_free;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_valid;
  logic [WIDTH-1:0]  w_data [NUM_CH];
  logic              w_accept;
  logic              w_bad_accept;

  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_ready = {out2_ready, out1_ready, out0_ready};

  // in_ready looks only at the addressed slot; an illegal select is always
  // taken so that a bad code can never wedge the producer.
  always_comb begin
    in_ready = 1'b1;
    case (set)
      SEL_CH0: in_ready = w_free[0];
      SEL_CH1: in_ready = w_free[1];
      SEL_CH2: in_ready = w_free[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign w_accept     = in_valid && in_ready;
  assign w_bad_accept = w_accept && !sel_is_channel(set);

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      localparam logic [1:0] c_SEL = 2'(k);

      assign w_load[k] = w_accept && (set == c_SEL);

      demux_out_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load[k]),
        .load_data (in_data),
        .ready     (w_ready[k]),
        .data      (w_data[k]),
        .valid     (w_valid[k]),
        .free      (w_free[k])
      );
    end
  endgenerate

  // err follows each accept by one cycle, so consecutive illegal accepts
  // hold it high continuously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err <= w_bad_accept;
      if (w_bad_accept && (r_err_count != c_ERR_MAX)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign out0_data  = w_data[0];
  assign out1_data  = w_data[1];
  assign out2_data  = w_data[2];
  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out2_valid = w_valid[2];
  assign err        = r_err;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: doc/demux16b3_buf.md
Name: demux16b3_buf

Overview:
- Buffered 1-to-3 demultiplexer for 16-bit words. It is the distributing counterpart of the 3-input/2-bit-select datapath muxes.
- Steers an incoming word and its 2-bit `set` code to one of three output channels.
- Each channel has a one-entry holding register and a valid/ready handshake.
- Used where a single result bus feeds three consumers (e.g. register-file write port, memory write data, PC/branch unit) that may stall independently.

Parameters:
- WIDTH, 16, data width of input and of every output channel.
- ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to distribute.
- set  input  2  destination select: 0→ch0, 1→ch1, 2→ch2, 3 illegal.
- in_valid  input  1  in_data/set are valid this cycle.
- in_ready  output  1  block accepts the word this cycle (combinational).
- out0_data, out1_data, out2_data  output  WIDTH each  channel data (registered).
- out0_valid, out1_valid, out2_valid  output  1 each  channel holds a word (registered).
- out0_ready, out1_ready, out2_ready  input  1 each  consumer takes the word this cycle.
- err  output  1  one-cycle pulse after an illegal-select word is accepted (registered).
- err_count  output  ERR_CNT_W  number of illegal-select words accepted, saturating.

Behaviour:
- Reset is asynchronous and active-high. While `reset`=1:
  - all outK_valid=0 and all outK_data=0;
  - err=0, err_count=0;
  - any held words are discarded. This applies to a reset asserted mid-transfer as well; no word survives reset.
- Channel K is "free" when !outK_valid, or when outK_valid && outK_ready (drains this cycle).
- in_ready is combinational:
  - set=K (K=0..2): in_ready = free(K);
  - set=3: in_ready = 1.
  - in_ready must not depend on in_valid.
- Accept = in_valid && in_ready.
- Accept with set=K:
  - next edge loads outK_data<=in_data and sets outK_valid<=1;
  - latency is 1 cycle, input to outK_valid;
  - simultaneous drain and reload of the same channel leaves outK_valid=1 with the new data (full throughput of 1 word/cycle per channel).
- Drain without reload: outK_valid && outK_ready && no accept to K → outK_valid<=0. outK_data holds its last value; it is not cleared.
- Stall: while outK_valid && !outK_ready, outK_data and outK_valid are held stable. A word for channel K is refused (in_ready=0). Words for other free channels are still accepted.
- Channels are independent. A drain on one channel and an accept to a different channel in the same cycle are both honoured.
- Accept with set=3:
  - the word is dropped; no channel changes;
  - err<=1 for exactly the next cycle;
  - err_count increments, saturating at 2^ERR_CNT_W−1 (255 by default; no wrap).
  - Back-to-back illegal accepts keep err high continuously and count each one.
- No accept → err<=0.
- outK_ready is ignored when outK_valid=0.
- Outputs only ever toggle on clk edges or on reset, except in_ready.

Decomposition:
- Shared package `proc16_pkg`:
  - select constants SEL_CH0=2'd0, SEL_CH1=2'd1, SEL_CH2=2'd2, SEL_BAD=2'd3;
  - default WIDTH=16.
- One natural sub-module, `demux_out_slot`, instantiated three times:
  - ports clk, reset, load, load_data, ready, data, valid, free;
  - contains the holding register, the valid flag and the free logic.
- The top level contains the select decode, in_ready mux, err pulse register and saturating counter.

Test Plan:
- Reset release, then in_data=16'hA5A5, set=1, in_valid=1 for 1 cycle, out1_ready=1 → out1_valid=1 with out1_data=16'hA5A5 exactly 1 cycle later; out0/out2 stay valid=0.
- Backpressure: out2_ready=0; send 16'h1111 set=2, then 16'h2222 set=2 → second word sees in_ready=0 and out2_data stays 16'h1111. Raise out2_ready → 16'h2222 appears the following cycle. Meanwhile 16'h3333 set=0 is accepted and appears on ch0.
- Streaming: out0_ready=1, in_valid=1 every cycle with set=0 and data 0..9 → in_ready constant 1; out0_data sequence 0..9 with no bubbles and no duplicates.
- Illegal select: 3 consecutive words with set=3 → in_ready=1 throughout; err high for 3 cycles starting 1 cycle later; err_count=3; no outK_valid asserted.
- Saturation: 300 illegal accepts → err_count stops at 255; err still pulses on each accept.
- Async reset mid-stall: out1 holding 16'hBEEF with out1_ready=0; assert reset between clock edges → out1_valid=0, out1_data=0 and err_count=0 immediately, without waiting for an edge. After release, first new accept behaves as in scenario 1.
